scope_trace_renderer: RTL and testbench
=======================================

Name: scope_trace_renderer

Overview:
- Upstream pixel source for the 640x480 VGA timing stage; produces the 4-bit palette index `pixel` for every (px, py) the timing stage presents.
- Captures a triggered record of 640 ADC samples into a double-buffered sample memory.
- Renders that record as a continuous trace over a graticule.
- Buffers swap only at the vertical-sync boundary, so a frame never shows a half-written record.

Parameters:
- SAMPLE_W, 8, ADC sample width (unsigned).
- NCOLS, 640, samples per record; equals the visible width.
- TRACE_BASE, 367, display row for sample value 0 (row = TRACE_BASE - sample).
- GRID_PITCH, 64, graticule spacing in px and py (power of two).
- AUTO_TIMEOUT, 4096, samples waited for a trigger before a forced capture.

Ports:
- pclk  in  1  pixel clock
- rst  in  1  reset, synchronous, active-high
- sample_in  in  8  ADC sample, unsigned
- sample_valid  in  1  one-cycle strobe qualifying sample_in
- trig_level  in  8  trigger threshold
- trig_rising  in  1  1 = rising-edge trigger, 0 = falling-edge trigger
- auto_mode  in  1  1 = force capture after AUTO_TIMEOUT samples without a trigger
- px  in  10  visible column from the timing stage
- py  in  10  visible row from the timing stage
- drawon  in  1  visible-area flag from the timing stage
- vsync  in  1  active-low vertical sync from the timing stage
- pixel  out  4  palette index
- triggered  out  1  pulses 1 cycle when a capture starts
- record_ready  out  1  high while a completed record waits for its swap

Behaviour:
- One clock: pclk. Reset is synchronous and active-high: rst is sampled on the rising edge of pclk.
- Reset values:
  - pixel=0, triggered=0, record_ready=0.
  - FSM=ARM; write pointer=0; timeout counter=0; display bank=0; prev-sample register=0.
  - Memory contents are not reset.
- Storage: two banks of NCOLS x SAMPLE_W with asynchronous read. The write bank is always the bank not being displayed.
- Capture FSM; it advances only on cycles with sample_valid=1:
  - ARM: on a valid sample, go to WAIT_TRIG. Latch the sample as "last".
  - WAIT_TRIG:
    - Rising trigger when last < trig_level and sample >= trig_level.
    - Falling trigger when last > trig_level and sample <= trig_level.
    - On trigger: write the sample at address 0, set ptr=1, pulse triggered, go to CAPTURE.
    - If auto_mode=1 and the timeout counter reaches AUTO_TIMEOUT-1: same action as a trigger (forced).
    - The timeout counter clears on entry to WAIT_TRIG.
  - CAPTURE: write the sample at ptr and increment ptr. After the write at NCOLS-1, go to DONE and set record_ready=1.
  - DONE: ignore samples. On the vsync falling edge (registered vsync 1 -> 0): toggle the display bank, clear record_ready, go to ARM.
- Simultaneous vsync falling edge and the final CAPTURE write: complete the write and enter DONE. The swap waits for the next vsync falling edge.
- A vsync edge in ARM, WAIT_TRIG or CAPTURE never toggles the bank.
- rst mid-capture: the partial record is discarded. The display bank returns to 0 and shows stale contents.
- Render (combinational index, registered output; pixel updates on the pclk edge after px/py change):
  - cur = display bank[px]. prev = registered cur of the previous column, updated whenever px differs from its registered value. At px=0, prev=cur.
  - yc = TRACE_BASE - cur; yp = TRACE_BASE - prev. Compute at 10 bits; no wrap is possible for 8-bit samples.
  - Priority, highest first:
    1. drawon=0 -> 0
    2. py within [min(yc,yp), max(yc,yp)] inclusive -> 14 (trace)
    3. px<8 and py == TRACE_BASE - trig_level -> 11 (trigger marker)
    4. py == 240 or px == 320 -> 7 (axes)
    5. px mod GRID_PITCH == 0 or py mod GRID_PITCH == 0 -> 8 (grid)
    6. otherwise 0
- px >= NCOLS: treated as drawon=0; no memory read occurs.

Decomposition:
- Shared package scope_pkg holds:
  - the palette index constants (BLACK=0, AXIS=7, GRID=8, MARKER=11, TRACE=14);
  - the visible-area constants 640/480;
  - the capture FSM state enum.
- One natural sub-module, scope_capture_fsm: trigger detection, timeout, write pointer, bank select.
- scope_trace_renderer instantiates it together with the two memory banks and the render logic.

Test Plan:
- Rising trigger: level=128, ramp 0..255 one sample per 4 clocks -> triggered pulses on sample 128; bank1[0]=128, bank1[639]=255 (the ramp saturates at 255); record_ready=1 after 640 writes.
- Swap timing: record completes mid-frame -> bank toggles only at the next vsync 1 -> 0. Frame N+1 at px=0 shows pixel=14 at py=239 (367-128).
- Trace continuity: samples 50 at px=9 and 150 at px=10 -> pixel=14 for py 217..317 inclusive at px=10; py=216 and py=318 -> 8 or 0.
- Auto mode: constant input 10, level=128, auto_mode=1 -> forced capture after 4096 samples, all entries 10. With auto_mode=0 -> no capture after 10000 samples.
- Falling trigger with a simultaneous event: final CAPTURE write on the same cycle as a vsync falling edge -> no swap that frame; swap at the following vsync edge.
- Reset mid-CAPTURE at ptr=300 -> FSM=ARM, record_ready=0, pixel=0, display bank=0 on the next cycle.

Source files
------------

// File: rtl/scope_pkg.sv
// Shared constants, palette indices, capture states and the sample-memory write request.
package scope_pkg;

  localparam int unsigned SAMPLE_W     = 8;
  localparam int unsigned NCOLS        = 640;
  localparam int unsigned NROWS        = 480;
  localparam int unsigned TRACE_BASE   = 367;
  localparam int unsigned GRID_PITCH   = 64;
  localparam int unsigned AUTO_TIMEOUT = 4096;
  localparam int unsigned ADDR_W       = 10;
  localparam int unsigned COORD_W      = 10;
  localparam int unsigned TMO_W        = 12;
  localparam int unsigned PIX_W        = 4;
  localparam int unsigned MARKER_W     = 8;
  localparam int unsigned AXIS_X       = NCOLS / 2;
  localparam int unsigned AXIS_Y       = NROWS / 2;

  localparam logic [PIX_W-1:0] BLACK  = 4'd0;
  localparam logic [PIX_W-1:0] AXIS   = 4'd7;
  localparam logic [PIX_W-1:0] GRID   = 4'd8;
  localparam logic [PIX_W-1:0] MARKER = 4'd11;
  localparam logic [PIX_W-1:0] TRACE  = 4'd14;

  typedef enum logic [1:0] {
    ST_ARM,
    ST_WAIT_TRIG,
    ST_CAPTURE,
    ST_DONE
  } cap_state_e;

  typedef struct packed {
    logic                en;
    logic                bank;
    logic [ADDR_W-1:0]   addr;
    logic [SAMPLE_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/scope_trace_renderer_if.sv
// Sample, trigger-control and video-timing bundle between the scope and its neighbours.
interface scope_trace_renderer_if;
  import scope_pkg::*;

  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] trig_level;
  logic                trig_rising;
  logic                auto_mode;
  logic [COORD_W-1:0]  px;
  logic [COORD_W-1:0]  py;
  logic                drawon;
  logic                vsync;
  logic [PIX_W-1:0]    pixel;
  logic                triggered;
  logic                record_ready;

  modport master (
    output sample_in, sample_valid, trig_level, trig_rising, auto_mode,
    output px, py, drawon, vsync,
    input  pixel, triggered, record_ready
  );

  modport slave (
    input  sample_in, sample_valid, trig_level, trig_rising, auto_mode,
    input  px, py, drawon, vsync,
    output pixel, triggered, record_ready
  );

endinterface

// File: rtl/scope_capture_fsm.sv
// Trigger detection, auto timeout, record write pointer and vsync-aligned bank swap.
module scope_capture_fsm
  import scope_pkg::*;
(
  input  logic                pclk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic                i_sample_valid,
  input  logic [SAMPLE_W-1:0] i_trig_level,
  input  logic                i_trig_rising,
  input  logic                i_auto_mode,
  input  logic                i_vsync,
  output wr_req_t             o_wr,
  output logic                o_disp_bank,
  output logic                o_triggered,
  output logic                o_record_ready
);

  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(AUTO_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(NCOLS - 1);

  cap_state_e          r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic [TMO_W-1:0]    r_timeout;
  logic [SAMPLE_W-1:0] r_last;
  logic                r_disp_bank;
  logic                r_triggered;
  logic                r_record_ready;
  logic                r_vsync_q;
  wr_req_t             r_wr;

  logic w_rise;
  logic w_fall;
  logic w_fire;
  logic w_vsync_fall;

  assign w_rise       = (r_last < i_trig_level) && (i_sample >= i_trig_level);
  assign w_fall       = (r_last > i_trig_level) && (i_sample <= i_trig_level);
  assign w_fire       = (i_trig_rising ? w_rise : w_fall) ||
                        (i_auto_mode && (r_timeout == TMO_LAST));
  assign w_vsync_fall = r_vsync_q && !i_vsync;

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state        <= ST_ARM;
      r_ptr          <= '0;
      r_timeout      <= '0;
      r_last         <= '0;
      r_disp_bank    <= 1'b0;
      r_triggered    <= 1'b0;
      r_record_ready <= 1'b0;
      r_vsync_q      <= 1'b0;
      r_wr           <= '0;
    end else begin
      r_vsync_q   <= i_vsync;
      r_triggered <= 1'b0;
      r_wr.en     <= 1'b0;
      case (r_state)
        ST_ARM: begin
          if (i_sample_valid) begin
            r_last    <= i_sample;
            r_timeout <= '0;
            r_state   <= ST_WAIT_TRIG;
          end
        end
        ST_WAIT_TRIG: begin
          if (i_sample_valid) begin
            r_last <= i_sample;
            if (w_fire) begin
              r_wr        <= '{en: 1'b1, bank: ~r_disp_bank, addr: ADDR_W'(0), data: i_sample};
              r_ptr       <= ADDR_W'(1);
              r_triggered <= 1'b1;
              r_state     <= ST_CAPTURE;
            end else begin
              r_timeout <= r_timeout + TMO_W'(1);
            end
          end
        end
        ST_CAPTURE: begin
          if (i_sample_valid) begin
            r_wr <= '{en: 1'b1, bank: ~r_disp_bank, addr: r_ptr, data: i_sample};
            if (r_ptr == PTR_LAST) begin
              r_record_ready <= 1'b1;
              r_state        <= ST_DONE;
            end else begin
              r_ptr <= r_ptr + ADDR_W'(1);
            end
          end
        end
        ST_DONE: begin
          // Swap only here, so an edge coinciding with the last write waits a frame.
          if (w_vsync_fall) begin
            r_disp_bank    <= ~r_disp_bank;
            r_record_ready <= 1'b0;
            r_state        <= ST_ARM;
          end
        end
        default: r_state <= ST_ARM;
      endcase
    end
  end

  assign o_wr           = r_wr;
  assign o_disp_bank    = r_disp_bank;
  assign o_triggered    = r_triggered;
  assign o_record_ready = r_record_ready;

endmodule

// File: rtl/scope_trace_renderer.sv
// Double-buffered scope record and trace/graticule pixel renderer for a 640x480 raster.
module scope_trace_renderer
  import scope_pkg::*;
(
  input  logic                 pclk,
  input  logic                 rst,
  scope_trace_renderer_if.slave bus
);

  localparam logic [COORD_W-1:0] GRID_MASK = COORD_W'(GRID_PITCH - 1);

  wr_req_t             w_wr;
  logic                w_disp_bank;
  logic                w_triggered;
  logic                w_record_ready;

  logic [SAMPLE_W-1:0] r_bank0 [NCOLS];
  logic [SAMPLE_W-1:0] r_bank1 [NCOLS];

  logic [COORD_W-1:0]  r_px;
  logic [SAMPLE_W-1:0] r_cur;
  logic [SAMPLE_W-1:0] r_prev;
  logic [PIX_W-1:0]    r_pixel;

  logic                w_in_range;
  logic [ADDR_W-1:0]   w_addr;
  logic [SAMPLE_W-1:0] w_cur;
  logic [SAMPLE_W-1:0] w_prev;
  logic                w_px_moved;
  logic [COORD_W-1:0]  w_yc;
  logic [COORD_W-1:0]  w_yp;
  logic [COORD_W-1:0]  w_lo;
  logic [COORD_W-1:0]  w_hi;
  logic [COORD_W-1:0]  w_marker_row;
  logic [PIX_W-1:0]    w_pixel_c;

  scope_capture_fsm u_fsm (
    .pclk           (pclk),
    .rst            (rst),
    .i_sample       (bus.sample_in),
    .i_sample_valid (bus.sample_valid),
    .i_trig_level   (bus.trig_level),
    .i_trig_rising  (bus.trig_rising),
    .i_auto_mode    (bus.auto_mode),
    .i_vsync        (bus.vsync),
    .o_wr           (w_wr),
    .o_disp_bank    (w_disp_bank),
    .o_triggered    (w_triggered),
    .o_record_ready (w_record_ready)
  );

  always_ff @(posedge pclk) begin
    if (w_wr.en) begin
      if (w_wr.bank) r_bank1[w_wr.addr] <= w_wr.data;
      else           r_bank0[w_wr.addr] <= w_wr.data;
    end
  end

  // Off-screen columns read a fixed address; the pixel is blanked anyway.
  assign w_in_range = bus.px < COORD_W'(NCOLS);
  assign w_addr     = w_in_range ? ADDR_W'(bus.px) : '0;
  assign w_cur      = w_disp_bank ? r_bank1[w_addr] : r_bank0[w_addr];

  // r_cur still holds the previous column's sample on the first cycle of a new column.
  assign w_px_moved = bus.px != r_px;
  assign w_prev     = (bus.px == '0) ? w_cur : (w_px_moved ? r_cur : r_prev);

  assign w_yc         = COORD_W'(TRACE_BASE) - COORD_W'(w_cur);
  assign w_yp         = COORD_W'(TRACE_BASE) - COORD_W'(w_prev);
  assign w_lo         = (w_yc < w_yp) ? w_yc : w_yp;
  assign w_hi         = (w_yc < w_yp) ? w_yp : w_yc;
  assign w_marker_row = COORD_W'(TRACE_BASE) - COORD_W'(bus.trig_level);

  always_comb begin
    w_pixel_c = BLACK;
    if (!bus.drawon || !w_in_range) begin
      w_pixel_c = BLACK;
    end else if (bus.py >= w_lo && bus.py <= w_hi) begin
      w_pixel_c = TRACE;
    end else if (bus.px < COORD_W'(MARKER_W) && bus.py == w_marker_row) begin
      w_pixel_c = MARKER;
    end else if (bus.py == COORD_W'(AXIS_Y) || bus.px == COORD_W'(AXIS_X)) begin
      w_pixel_c = AXIS;
    end else if ((bus.px & GRID_MASK) == '0 || (bus.py & GRID_MASK) == '0) begin
      w_pixel_c = GRID;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_px    <= '0;
      r_cur   <= '0;
      r_prev  <= '0;
      r_pixel <= BLACK;
    end else begin
      r_px    <= bus.px;
      r_cur   <= w_cur;
      r_pixel <= w_pixel_c;
      if (w_px_moved) r_prev <= r_cur;
    end
  end

  assign bus.pixel        = r_pixel;
  assign bus.triggered    = w_triggered;
  assign bus.record_ready = w_record_ready;

endmodule

// File: tb/tb_scope_trace_renderer.sv
// Directed bench: rising/falling/auto captures, vsync-aligned swaps, trace rendering, mid-capture reset.
module tb_scope_trace_renderer;
  import scope_pkg::*;

  logic pclk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 pclk = ~pclk;

  scope_trace_renderer_if bus ();

  scope_trace_renderer dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One valid sample; gap>0 drops valid and idles, gap=0 leaves valid high for back-to-back use.
  task automatic send(input logic [7:0] v, input int gap, output logic trig);
    @(negedge pclk);
    bus.sample_in    = v;
    bus.sample_valid = 1'b1;
    @(posedge pclk);
    #1;
    trig = bus.triggered;
    if (gap > 0) begin
      @(negedge pclk);
      bus.sample_valid = 1'b0;
      repeat (gap - 1) @(posedge pclk);
    end
  endtask

  task automatic idle();
    @(negedge pclk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic show(input int x, input int y, input logic d, output logic [3:0] p);
    @(negedge pclk);
    bus.px     = COORD_W'(x);
    bus.py     = COORD_W'(y);
    bus.drawon = d;
    @(posedge pclk);
    #1;
    p = bus.pixel;
  endtask

  task automatic vsync_pulse();
    @(negedge pclk);
    bus.vsync = 1'b0;
    @(posedge pclk);
    #1;
  endtask

  initial begin
    logic       t;
    logic       seen;
    logic [3:0] p;

    rst              = 1'b1;
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.trig_level   = 8'd128;
    bus.trig_rising  = 1'b1;
    bus.auto_mode    = 1'b0;
    bus.px           = '0;
    bus.py           = '0;
    bus.drawon       = 1'b0;
    bus.vsync        = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    check("reset_pixel", 32'(bus.pixel), 0);
    check("reset_triggered", 32'(bus.triggered), 0);
    check("reset_record_ready", 32'(bus.record_ready), 0);
    @(negedge pclk);
    rst = 1'b0;

    // Rising ramp capture into bank 1
    seen = 1'b0;
    for (int v = 0; v < 128; v++) begin
      send(8'(v), 3, t);
      seen |= t;
    end
    check("ramp_no_early_trig", 32'(seen), 0);
    send(8'd128, 3, t);
    check("ramp_trig_at_128", 32'(t), 1);
    seen = 1'b0;
    for (int v = 129; v < 256; v++) begin
      send(8'(v), 3, t);
      seen |= t;
    end
    for (int i = 0; i < 511; i++) begin
      send(8'd255, 3, t);
      seen |= t;
    end
    check("ramp_single_trig", 32'(seen), 0);
    check("ramp_rr_before_last", 32'(bus.record_ready), 0);
    send(8'd255, 3, t);
    check("ramp_rr_after_640", 32'(bus.record_ready), 1);
    send(8'd0, 3, t);
    send(8'd200, 3, t);
    idle();
    repeat (20) @(posedge pclk);
    #1;
    check("no_swap_midframe", 32'(bus.record_ready), 1);
    vsync_pulse();
    check("swap_clears_rr", 32'(bus.record_ready), 0);
    @(negedge pclk);
    bus.vsync = 1'b1;

    // Render bank 1 (ramp record)
    show(0, 239, 1'b1, p);   check("b1_px0_trace", 32'(p), 14);
    show(0, 238, 1'b1, p);   check("b1_px0_grid", 32'(p), 8);
    show(0, 240, 1'b1, p);   check("b1_px0_axis", 32'(p), 7);
    show(4, 0, 1'b1, p);
    show(5, 239, 1'b1, p);   check("b1_marker", 32'(p), 11);
    show(5, 234, 1'b1, p);   check("b1_px5_trace", 32'(p), 14);
    show(638, 0, 1'b1, p);
    show(639, 112, 1'b1, p); check("b1_px639_trace", 32'(p), 14);
    show(639, 113, 1'b1, p); check("b1_px639_blank", 32'(p), 0);
    show(639, 112, 1'b0, p); check("drawon_off", 32'(p), 0);
    show(700, 240, 1'b1, p); check("px_out_of_range", 32'(p), 0);

    // Falling capture into bank 0; final write coincides with a vsync falling edge
    bus.trig_level  = 8'd100;
    bus.trig_rising = 1'b0;
    send(8'd255, 0, t);
    send(8'd100, 0, t);
    check("fall_trig", 32'(t), 1);
    for (int i = 1; i < 639; i++) begin
      send((i == 9) ? 8'd50 : ((i == 10) ? 8'd150 : 8'd100), 0, t);
    end
    @(negedge pclk);
    bus.sample_in    = 8'd100;
    bus.sample_valid = 1'b1;
    bus.vsync        = 1'b0;
    @(posedge pclk);
    #1;
    check("simul_rr_set", 32'(bus.record_ready), 1);
    idle();
    repeat (10) @(posedge pclk);
    #1;
    check("simul_no_swap", 32'(bus.record_ready), 1);
    show(0, 239, 1'b1, p);   check("simul_still_bank1", 32'(p), 14);
    @(negedge pclk);
    bus.vsync = 1'b1;
    repeat (3) @(posedge pclk);
    vsync_pulse();
    check("simul_swap_next_edge", 32'(bus.record_ready), 0);
    @(negedge pclk);
    bus.vsync = 1'b1;

    // Render bank 0 (falling record)
    show(0, 267, 1'b1, p);   check("b0_px0_trace", 32'(p), 14);
    show(9, 0, 1'b1, p);
    show(10, 217, 1'b1, p);  check("cont_top", 32'(p), 14);
    show(10, 317, 1'b1, p);  check("cont_bottom", 32'(p), 14);
    show(10, 240, 1'b1, p);  check("cont_over_axis", 32'(p), 14);
    show(10, 216, 1'b1, p);  check("cont_above", 32'(p), 0);
    show(10, 318, 1'b1, p);  check("cont_below", 32'(p), 0);

    // Auto-mode forced capture into bank 1
    bus.trig_level  = 8'd128;
    bus.trig_rising = 1'b1;
    bus.auto_mode   = 1'b1;
    send(8'd10, 0, t);
    seen = 1'b0;
    for (int i = 0; i < 4095; i++) begin
      send(8'd10, 0, t);
      seen |= t;
    end
    check("auto_no_early", 32'(seen), 0);
    send(8'd10, 0, t);
    check("auto_forced", 32'(t), 1);
    for (int i = 0; i < 639; i++) send(8'd10, 0, t);
    idle();
    check("auto_rr", 32'(bus.record_ready), 1);
    vsync_pulse();
    @(negedge pclk);
    bus.vsync = 1'b1;
    show(319, 0, 1'b1, p);
    show(320, 357, 1'b1, p); check("auto_trace_axis_col", 32'(p), 14);
    show(320, 356, 1'b1, p); check("auto_axis", 32'(p), 7);
    show(0, 357, 1'b1, p);   check("auto_px0", 32'(p), 14);

    // Auto off: no capture on a flat signal
    bus.auto_mode = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      send(8'd10, 0, t);
      seen |= t;
    end
    idle();
    check("manual_no_capture", 32'(seen), 0);
    check("manual_rr", 32'(bus.record_ready), 0);

    // Reset partway through a capture (writes land in bank 0)
    send(8'd200, 0, t);
    check("cap_trig", 32'(t), 1);
    for (int i = 0; i < 299; i++) send(8'd200, 0, t);
    check("cap_ptr_300", 32'(dut.u_fsm.r_ptr), 300);
    @(negedge pclk);
    bus.sample_valid = 1'b0;
    rst              = 1'b1;
    @(posedge pclk);
    #1;
    check("rst_state_arm", 32'(dut.u_fsm.r_state), 32'(ST_ARM));
    check("rst_rr", 32'(bus.record_ready), 0);
    check("rst_pixel", 32'(bus.pixel), 0);
    check("rst_disp_bank", 32'(dut.u_fsm.r_disp_bank), 0);
    @(negedge pclk);
    rst = 1'b0;
    show(0, 167, 1'b1, p);   check("rst_shows_bank0", 32'(p), 14);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
